// File: rtl/mem_subsystem_rr.sv
// Shared single-port word array behind a round-robin arbiter, gated by PLL lock.
// Service starts only after lock has been continuously high for LOCK_WAIT cycles.
module mem_subsystem_rr #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned LOCK_WAIT = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       lock,
  input  logic                       chip_en,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH-1:0]          req_wr,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  output logic [NUM_CH-1:0]          req_ready,
  output logic [NUM_CH-1:0]          rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(LOCK_WAIT + 1);
  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0]  rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               grant_en;
  logic [NUM_CH-1:0]  lo_mask;
  logic [NUM_CH-1:0]  req_hi;
  logic [NUM_CH-1:0]  cand;
  logic [NUM_CH-1:0]  gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic               xfer;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Round-robin: prefer requesters at or above ptr, wrap to the lowest otherwise;
  // the lowest set bit is isolated with x & -x.
  always_comb begin
    grant_en = (state_q == RUN) && lock && chip_en;
    lo_mask  = (NUM_CH'(1) << ptr_q) - NUM_CH'(1);
    req_hi   = req_valid & ~lo_mask;
    cand     = (req_hi != '0) ? req_hi : req_valid;
    gnt      = grant_en ? (cand & (~cand + NUM_CH'(1))) : '0;
  end

  always_comb begin
    gnt_idx   = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      if (gnt[j]) begin
        gnt_idx   = PTR_W'(j);
        sel_wr    = req_wr[j];
        sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[j*DATA_W +: DATA_W];
      end
    end
    xfer = |gnt;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;

    case (state_q)
      WAIT_LOCK: begin
        if (!lock) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(LOCK_WAIT - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
    endcase

    if (xfer) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end

    if (xfer && !sel_wr) begin
      rd_valid_d = gnt;
      rd_data_d  = mem[sel_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      ptr_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Array is never cleared; reset only blocks a write landing on the reset edge.
  always_ff @(posedge clock) begin
    if (!reset && xfer && sel_wr) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  assign req_ready = gnt;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign ready     = (state_q == RUN);

endmodule

// File: tb/tb_mem_subsystem_rr.sv
// Directed bench for mem_subsystem_rr: read expectations go into a scoreboard queue,
// a negedge monitor pops and compares whenever rd_valid is presented.
module tb_mem_subsystem_rr;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned LOCK_WAIT = 16;

  logic                     clock;
  logic                     reset;
  logic                     lock;
  logic                     chip_en;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_wr;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH-1:0]        rd_valid;
  logic [DATA_W-1:0]        rd_data;
  logic                     ready;

  typedef struct {
    logic [NUM_CH-1:0] ch;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] model [int];
  int                checks   = 0;
  int                failures = 0;

  mem_subsystem_rr #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .NUM_CH(NUM_CH),
    .LOCK_WAIT(LOCK_WAIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .lock(lock),
    .chip_en(chip_en),
    .req_valid(req_valid),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .ready(ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [NUM_CH-1:0] ch, input logic [DATA_W-1:0] data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic set_ch(input int ch, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data);
    req_valid[ch]                  = 1'b1;
    req_wr[ch]                     = wr;
    req_addr[ch*ADDR_W +: ADDR_W]  = addr;
    req_wdata[ch*DATA_W +: DATA_W] = data;
  endtask

  // Single request on one channel; waits (bounded) for its grant, then records the effect.
  task automatic do_req(input int ch, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data);
    int n;
    logic [NUM_CH-1:0] oh;
    oh        = '0;
    oh[ch]    = 1'b1;
    req_valid = '0;
    set_ch(ch, wr, addr, data);
    settle();
    n = 0;
    while (!req_ready[ch] && n < 20) begin
      step();
      n++;
    end
    check("req_grant", {30'd0, req_ready}, {30'd0, oh});
    if (req_ready[ch]) begin
      if (wr) model[int'(addr)] = data;
      else    push(oh, model[int'(addr)]);
    end
    step();
    req_valid = '0;
  endtask

  task automatic wait_ready(input string name, input int exp_edges);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      step();
      n++;
    end
    check(name, n, exp_edges);
  endtask

  always @(negedge clock) begin
    if (rd_valid !== '0) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got rd_valid=%0h rd_data=%0h expected no read return",
                 rd_valid, rd_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rd_valid !== e.ch || rd_data !== e.data) begin
          failures++;
          $display("FAIL rd_return: got rd_valid=%0h rd_data=%0h expected rd_valid=%0h rd_data=%0h",
                   rd_valid, rd_data, e.ch, e.data);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    lock      = 1'b1;
    chip_en   = 1'b1;
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    set_ch(0, 1'b1, 10'h000, 16'h1111);
    set_ch(1, 1'b1, 10'h001, 16'h2222);
    step();
    step();
    reset = 1'b0;
    settle();

    // Startup: 16 edges of lock before ready, no grants while waiting
    check("startup_ready", {31'd0, ready}, 32'd0);
    check("startup_gnt", {30'd0, req_ready}, 32'd0);
    for (int k = 1; k < 16; k++) begin
      step();
      check("startup_ready", {31'd0, ready}, 32'd0);
      check("startup_gnt", {30'd0, req_ready}, 32'd0);
    end
    step();
    check("startup_ready_up", {31'd0, ready}, 32'd1);
    check("startup_first_gnt", {30'd0, req_ready}, 32'b01);
    model[0] = 16'h1111;
    step();
    req_valid[0] = 1'b0;
    settle();
    check("startup_second_gnt", {30'd0, req_ready}, 32'b10);
    model[1] = 16'h2222;
    step();
    req_valid = '0;

    // Write then read-back on the following cycle, top address
    do_req(0, 1'b1, 10'h3FF, 16'hA5A5);
    do_req(0, 1'b0, 10'h3FF, 16'h0000);
    do_req(1, 1'b1, 10'h002, 16'h3333);

    // Round-robin with both channels reading continuously; ptr is 0 here
    set_ch(0, 1'b0, 10'h000, 16'h0);
    set_ch(1, 1'b0, 10'h001, 16'h0);
    settle();
    for (int i = 0; i < 4; i++) begin
      logic [NUM_CH-1:0] eg;
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_grant", {30'd0, req_ready}, {30'd0, eg});
      push(eg, (i % 2 == 0) ? 16'h1111 : 16'h2222);
      step();
    end
    req_valid = '0;

    // chip_en low: no grants, ptr held at 1 so ch1 wins first afterwards
    do_req(0, 1'b0, 10'h002, 16'h0);
    chip_en = 1'b0;
    set_ch(0, 1'b0, 10'h000, 16'h0);
    set_ch(1, 1'b0, 10'h001, 16'h0);
    settle();
    for (int i = 0; i < 3; i++) begin
      check("chip_en_low_gnt", {30'd0, req_ready}, 32'd0);
      step();
    end
    chip_en = 1'b1;
    settle();
    check("chip_en_first_gnt", {30'd0, req_ready}, 32'b10);
    push(2'b10, 16'h2222);
    step();
    check("chip_en_second_gnt", {30'd0, req_ready}, 32'b01);
    push(2'b01, 16'h1111);
    step();
    req_valid = '0;

    // Read granted on last RUN edge still returns; lock loss removes grants at once
    do_req(1, 1'b0, 10'h001, 16'h0);
    lock = 1'b0;
    set_ch(0, 1'b0, 10'h000, 16'h0);
    settle();
    check("lockloss_gnt", {30'd0, req_ready}, 32'd0);
    step();
    lock = 1'b1;
    settle();
    check("lockloss_ready", {31'd0, ready}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      step();
      check("glitch_ready", {31'd0, ready}, 32'd0);
      check("glitch_gnt", {30'd0, req_ready}, 32'd0);
    end
    lock = 1'b0;
    step();
    lock = 1'b1;
    settle();
    for (int k = 1; k < 16; k++) begin
      step();
      check("glitch_ready", {31'd0, ready}, 32'd0);
    end
    step();
    check("glitch_ready_up", {31'd0, ready}, 32'd1);
    check("glitch_first_gnt", {30'd0, req_ready}, 32'b01);
    push(2'b01, 16'h1111);
    step();
    req_valid = '0;

    // Reset on a write transfer edge: the write must not land
    do_req(0, 1'b1, 10'h005, 16'h5555);
    set_ch(0, 1'b1, 10'h005, 16'hDEAD);
    reset = 1'b1;
    settle();
    check("rst_wr_gnt", {30'd0, req_ready}, 32'b01);
    step();
    req_valid = '0;
    reset     = 1'b0;
    settle();
    check("rst_wr_ready", {31'd0, ready}, 32'd0);
    wait_ready("rst_wr_relock", 16);
    do_req(0, 1'b0, 10'h005, 16'h0);

    // Reset on a read transfer edge: return is lost, outputs cleared
    set_ch(1, 1'b0, 10'h3FF, 16'h0);
    reset = 1'b1;
    settle();
    check("rst_rd_gnt", {30'd0, req_ready}, 32'b10);
    step();
    req_valid = '0;
    reset     = 1'b0;
    settle();
    check("rst_rd_valid", {30'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("rst_rd_ready", {31'd0, ready}, 32'd0);
    check("rst_rd_gnt_after", {30'd0, req_ready}, 32'd0);
    wait_ready("rst_rd_relock", 16);
    do_req(1, 1'b0, 10'h3FF, 16'h0);
    do_req(0, 1'b0, 10'h000, 16'h0);
    do_req(1, 1'b0, 10'h002, 16'h0);

    step();
    step();
    step();
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
